sound_event_ctrl: RTL
=====================

// Module: sound_event_ctrl
// PURPOSE
//  Drives the seven active-high mute ("off") controls of the sound mixer from game-logic event strobes.
//  Channels: pacman chomp, ghost siren, pacman death, four per-ghost "ghost eaten" tones.
//  Each channel is unmuted for a programmed duration, measured on a shared millisecond tick.
//  Sits between the game FSM and the mixer; all outputs are registered.
// PARAMETERS
//  TICK_DIV      100000  clk cycles per tick (1 ms at 100 MHz); must be >= 2
//  PELLET_TICKS  250     chomp duration in ticks; retriggerable
//  DEATH_TICKS   1500    death jingle duration in ticks; one-shot
//  EAT_TICKS     500     per-ghost eaten tone duration in ticks; retriggerable
//  CNT_W         11      timer width; must satisfy 2**CNT_W > max(*_TICKS)
// PORTS
//  clk            in   1  system clock
//  reset          in   1  asynchronous, active-low reset
//  game_running   in   1  level; high while a maze is in play
//  evt_pellet     in   1  1-cycle strobe: pellet eaten
//  evt_death      in   1  1-cycle strobe: pacman caught
//  evt_ghost_eat  in   4  1-cycle strobes: [0] blinky, [1] inky, [2] pinky, [3] clyde eaten
//  mute_all       in   1  level; forces every channel off
//  off            out  7  [0] chomp, [1] siren, [2] death, [3:6] ghost eaten blinky..clyde; 1 = silent
//  death_busy     out  1  high while the death jingle plays
// BEHAVIOUR
//  - Reset (reset==0, async): off = 7'h7F, death_busy = 0, all timers = 0, tick divider = 0, FSM = IDLE.
//  - Tick: divider counts 0..TICK_DIV-1; tick = 1 for one cycle when it wraps. Free-running outside reset.
//  - Timer (per channel): an event loads the timer with its duration. On each tick, a nonzero timer decrements.
//    The channel is active while the timer != 0.
//    The resulting duration is between (N-1)*TICK_DIV+1 and N*TICK_DIV cycles.
//  - Load and tick in the same cycle: load wins; no decrement that cycle.
//  - Latency: a strobe sampled at edge k produces the off bit change visible after edge k+1. This is one register stage.
//  - FSM states: IDLE, PLAY, DEATH.
//    IDLE -> PLAY when game_running==1.
//    PLAY -> IDLE when game_running==0. Chomp and eat timers are cleared.
//    PLAY -> DEATH on evt_death. The death timer is loaded with DEATH_TICKS. Chomp and eat timers are cleared.
//    DEATH -> PLAY when the death timer reaches 0 and game_running==1.
//    DEATH -> IDLE when the death timer reaches 0 and game_running==0.
//    DEATH is not aborted by game_running dropping.
//  - Event acceptance:
//    evt_pellet and evt_ghost_eat are accepted only in PLAY.
//    evt_death is accepted only in PLAY. A second evt_death during DEATH is ignored; there is no retrigger.
//    In IDLE every strobe is ignored.
//  - Simultaneous events: evt_death in the same cycle as evt_pellet or evt_ghost_eat -> death wins and the others are dropped.
//    Multiple evt_ghost_eat bits in one cycle each load their own timer.
//  - Output equations (registered):
//    off[0]   = !(PLAY && chomp_t!=0)
//    off[1]   = !(PLAY)   (siren plays for the whole PLAY state)
//    off[2]   = !(DEATH)
//    off[3+i] = !(PLAY && eat_t[i]!=0)
//    death_busy = DEATH.
//    mute_all==1 forces off=7'h7F on the next edge but does not stop the timers or the FSM.
//  - Reset mid-jingle: everything returns to reset values immediately; there is no residual tone.
// STRUCTURE
//  - Shared package sound_pkg:
//    state enum snd_state_t {IDLE, PLAY, DEATH}
//    channel index constants CH_CHOMP=0, CH_SIREN=1, CH_DEATH=2, CH_EAT0=3
//    NUM_SND_CH=7.
//  - Sub-module sound_hold_timer #(CNT_W): inputs load, load_val, tick, clr; outputs active, cnt.
//    Instantiated 6 times: chomp, death, and eat[0..3].
//  - Tick divider and FSM live in the top level.
// TESTING (TICK_DIV=4, PELLET_TICKS=3, DEATH_TICKS=5, EAT_TICKS=2)
//  1. Reset released, game_running=0, pulse all events -> off stays 7'h7F, death_busy=0.
//  2. game_running=1 -> off[1]=0 one edge later. Then pulse evt_pellet -> off[0]=0 for 9..12 cycles, then 1.
//  3. evt_pellet re-pulsed every 6 cycles for 30 cycles -> off[0] held 0 without a gap. It returns to 1 within 12 cycles after the last pulse.
//  4. evt_ghost_eat=4'b0101 in one cycle -> off[3] and off[5] go to 0 together for 5..8 cycles. off[4] and off[6] stay 1.
//  5. evt_death together with evt_pellet while a chomp is active -> off=7'b1111011, death_busy=1 for 17..20 cycles.
//     A second evt_death mid-jingle does not extend it. Afterwards off[1]=0 and off[0]=1.
//  6. Assert reset mid-DEATH -> off=7'h7F and death_busy=0 in the same cycle, asynchronously.
//     Also check mute_all=1 during PLAY -> off=7'h7F while the timers continue to count.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types and channel map for the sound event controller.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DEATH = 2'd2
  } snd_state_t;

  localparam int CH_CHOMP   = 0;
  localparam int CH_SIREN   = 1;
  localparam int CH_DEATH   = 2;
  localparam int CH_EAT0    = 3;
  localparam int NUM_SND_CH = 7;
  localparam int NUM_GHOSTS = 4;

endpackage

// File: rtl/sound_hold_timer.sv
// Down-counting hold timer: loaded by an event, decremented on each tick,
// active while nonzero. Clear beats load, load beats the tick decrement.
module sound_hold_timer #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  input  logic             clr,
  output logic             active,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign active = (cnt != '0);

endmodule

// File: rtl/sound_event_ctrl.sv
// Turns game event strobes into registered mute controls for the sound mixer.
// state | meaning
// IDLE  | no maze in play, all channels silent
// PLAY  | maze in play: siren on, chomp/eat tones follow their timers
// DEATH | death jingle playing; runs to completion regardless of game_running
module sound_event_ctrl
  import sound_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int PELLET_TICKS = 250,
  parameter int DEATH_TICKS  = 1500,
  parameter int EAT_TICKS    = 500,
  parameter int CNT_W        = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  game_running,
  input  logic                  evt_pellet,
  input  logic                  evt_death,
  input  logic [NUM_GHOSTS-1:0] evt_ghost_eat,
  input  logic                  mute_all,
  output logic [NUM_SND_CH-1:0] off,
  output logic                  death_busy
);

  localparam int DIV_W = $clog2(TICK_DIV);

  logic [DIV_W-1:0]                  div_cnt;
  logic                              tick;
  snd_state_t                        state, state_nxt;
  logic                              in_play, hold_clr, chomp_load, death_load, death_done;
  logic [NUM_GHOSTS-1:0]             eat_load, eat_active;
  logic                              chomp_active, death_active;
  logic [CNT_W-1:0]                  chomp_cnt, death_cnt;
  logic [NUM_GHOSTS-1:0][CNT_W-1:0]  eat_cnt;
  logic [NUM_SND_CH-1:0]             off_nxt;
  logic                              busy_nxt;
  logic                              unused_cnt;

  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Death beats any same-cycle pellet/eat strobe, and leaving PLAY silences the hold tones.
  assign in_play    = (state == PLAY);
  assign death_load = in_play && evt_death;
  assign hold_clr   = in_play && (evt_death || !game_running);
  assign chomp_load = in_play && evt_pellet && !evt_death;
  assign eat_load   = {NUM_GHOSTS{in_play && !evt_death}} & evt_ghost_eat;
  // Leave DEATH on the same edge the jingle timer reaches zero.
  assign death_done = !death_active || ((death_cnt == CNT_W'(1)) && tick);

  sound_hold_timer #(.CNT_W(CNT_W)) u_chomp (
    .clk(clk), .reset(reset), .load(chomp_load), .load_val(CNT_W'(PELLET_TICKS)),
    .tick(tick), .clr(hold_clr), .active(chomp_active), .cnt(chomp_cnt)
  );

  sound_hold_timer #(.CNT_W(CNT_W)) u_death (
    .clk(clk), .reset(reset), .load(death_load), .load_val(CNT_W'(DEATH_TICKS)),
    .tick(tick), .clr(1'b0), .active(death_active), .cnt(death_cnt)
  );

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_eat
    sound_hold_timer #(.CNT_W(CNT_W)) u_eat (
      .clk(clk), .reset(reset), .load(eat_load[g]), .load_val(CNT_W'(EAT_TICKS)),
      .tick(tick), .clr(hold_clr), .active(eat_active[g]), .cnt(eat_cnt[g])
    );
  end

  assign unused_cnt = ^{chomp_cnt, eat_cnt};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (game_running) state_nxt = PLAY;
      PLAY:    if (evt_death) state_nxt = DEATH;
               else if (!game_running) state_nxt = IDLE;
      DEATH:   if (death_done) state_nxt = game_running ? PLAY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    off_nxt           = '1;
    busy_nxt          = (state == DEATH);
    off_nxt[CH_CHOMP] = !(in_play && chomp_active);
    off_nxt[CH_SIREN] = !in_play;
    off_nxt[CH_DEATH] = (state != DEATH);
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      off_nxt[CH_EAT0 + i] = !(in_play && eat_active[i]);
    end
    if (mute_all) off_nxt = '1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      off        <= '1;
      death_busy <= 1'b0;
    end else begin
      off        <= off_nxt;
      death_busy <= busy_nxt;
    end
  end

endmodule
